// File: rtl/sram_like_resp.sv
// sram_like_resp: responder end of the SRAM-like data bus (req / addr_ok / data_ok).
// Accepted requests go straight to a 1-cycle-latency synchronous RAM and are
// answered in order after at least LATENCY cycles, with up to DEPTH outstanding.
// Optional build macro SRAM_LIKE_RAND_DELAY_EN: LFSR-driven addr_ok throttling
// and 0..3 cycles of extra response delay per accepted request.

module sram_like_resp #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned ADDR_W  = 16,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_sram_req,
  input  logic              data_sram_wr,
  input  logic [1:0]        data_sram_size,
  input  logic [3:0]        data_sram_wstrb,
  input  logic [31:0]       data_sram_addr,
  input  logic [31:0]       data_sram_wdata,
  output logic              data_sram_addr_ok,
  output logic              data_sram_data_ok,
  output logic [31:0]       data_sram_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned SLOTS = 1 << IDX_W;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned CD_W  = 5;

  // Circular response queue; pointers carry one extra wrap bit.
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CD_W-1:0]  cd_q   [SLOTS];
  logic [31:0]      data_q [SLOTS];
  logic             cap_q  [SLOTS];
  logic             rd_q   [SLOTS];
  logic             cap_pend_q;
  logic [IDX_W-1:0] cap_idx_q;

  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] hd_idx;
  logic             empty;
  logic             accept;
  logic             head_cap;
  logic             head_ready;
  logic [31:0]      head_data;
  logic [CD_W-1:0]  cd_init;
  logic             throttle;
  logic             unused_bits;

`ifdef SRAM_LIKE_RAND_DELAY_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16,14,13,11
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // LFSR register, reloaded with SEED on reset
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign throttle    = lfsr_q[0];
  assign cd_init     = CD_W'(LATENCY - 1) + CD_W'(lfsr_q[2:1]);
  assign unused_bits = ^{data_sram_size, data_sram_addr[1:0], data_sram_addr[31:ADDR_W+2]};
`else
  assign throttle    = 1'b0;
  assign cd_init     = CD_W'(LATENCY - 1);
  assign unused_bits = ^{data_sram_size, data_sram_addr[1:0], data_sram_addr[31:ADDR_W+2], SEED};
`endif

  // Handshake, RAM drive, response selection and pointer/count next-state
  always_comb begin
    wr_idx            = wr_ptr_q[IDX_W-1:0];
    hd_idx            = rd_ptr_q[IDX_W-1:0];
    empty             = (wr_ptr_q == rd_ptr_q);
    data_sram_addr_ok = ~reset & (count_q < CNT_W'(DEPTH)) & ~throttle;
    accept            = data_sram_req & data_sram_addr_ok;

    ram_en    = accept;
    ram_we    = (accept & data_sram_wr) ? data_sram_wstrb : '0;
    ram_addr  = data_sram_addr[ADDR_W+1:2];
    ram_wdata = data_sram_wdata;

    // Entry accepted last cycle has its RAM data on ram_rdata right now;
    // let it answer directly instead of waiting a cycle for capture.
    head_cap = cap_pend_q & (cap_idx_q == hd_idx);
    if (cap_q[hd_idx])     head_data = data_q[hd_idx];
    else if (rd_q[hd_idx]) head_data = ram_rdata;
    else                   head_data = '0;

    head_ready        = ~empty & (cd_q[hd_idx] == '0) & (cap_q[hd_idx] | head_cap);
    data_sram_data_ok = ~reset & head_ready;
    data_sram_rdata   = data_sram_data_ok ? head_data : '0;

    wr_ptr_d = wr_ptr_q + PTR_W'(accept);
    rd_ptr_d = rd_ptr_q + PTR_W'(data_sram_data_ok);
    count_d  = count_q + CNT_W'(accept) - CNT_W'(data_sram_data_ok);
  end

  // Queue state: push on accept, capture one cycle later, count down, pop on data_ok
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cap_pend_q <= 1'b0;
      cap_idx_q  <= '0;
      for (int unsigned i = 0; i < SLOTS; i++) begin
        cd_q[IDX_W'(i)]   <= '0;
        data_q[IDX_W'(i)] <= '0;
        cap_q[IDX_W'(i)]  <= 1'b0;
        rd_q[IDX_W'(i)]   <= 1'b0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int unsigned i = 0; i < SLOTS; i++) begin
        if (cd_q[IDX_W'(i)] != '0) cd_q[IDX_W'(i)] <= cd_q[IDX_W'(i)] - CD_W'(1);
      end
      if (cap_pend_q) begin
        data_q[cap_idx_q] <= rd_q[cap_idx_q] ? ram_rdata : '0;
        cap_q[cap_idx_q]  <= 1'b1;
      end
      if (accept) begin
        cd_q[wr_idx]  <= cd_init;
        rd_q[wr_idx]  <= ~data_sram_wr;
        cap_q[wr_idx] <= 1'b0;
      end
      cap_pend_q <= accept;
      cap_idx_q  <= wr_idx;
    end
  end

endmodule

// File: tb/tb_sram_like_resp.sv
// Bench for sram_like_resp: three instances with different DEPTH/LATENCY,
// each backed by a simple synchronous RAM model, checked against an
// in-order response scoreboard and a reference memory.

module tb_sram_like_resp;

  localparam int N = 3;

  function automatic int dep_of(input int g);
    return (g == 1) ? 4 : 2;
  endfunction

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
  endfunction

  function automatic logic [31:0] init_word(input int w);
    return {16'(w * 7) ^ 16'hC0DE, 16'(w)};
  endfunction

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [N-1:0]       req, wr, addr_ok, data_ok, ram_en;
  logic [N-1:0][1:0]  size;
  logic [N-1:0][3:0]  wstrb, ram_we;
  logic [N-1:0][31:0] addr, wdata, rdata, ram_wdata;
  logic [N-1:0][15:0] ram_addr;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [31:0] mem [65536];
    logic [31:0] mem_rd;

    initial begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_word(i);
    end

    always @(posedge clk) begin
      if (ram_en[g]) begin
        mem_rd <= mem[ram_addr[g]];
        for (int b = 0; b < 4; b++)
          if (ram_we[g][b]) mem[ram_addr[g]][8*b +: 8] <= ram_wdata[g][8*b +: 8];
      end
    end

    sram_like_resp #(
      .DEPTH  (dep_of(g)),
      .LATENCY(lat_of(g)),
      .ADDR_W (16),
      .SEED   (16'hACE1)
    ) u_dut (
      .clk              (clk),
      .reset            (reset),
      .data_sram_req    (req[g]),
      .data_sram_wr     (wr[g]),
      .data_sram_size   (size[g]),
      .data_sram_wstrb  (wstrb[g]),
      .data_sram_addr   (addr[g]),
      .data_sram_wdata  (wdata[g]),
      .data_sram_addr_ok(addr_ok[g]),
      .data_sram_data_ok(data_ok[g]),
      .data_sram_rdata  (rdata[g]),
      .ram_en           (ram_en[g]),
      .ram_we           (ram_we[g]),
      .ram_addr         (ram_addr[g]),
      .ram_wdata        (ram_wdata[g]),
      .ram_rdata        (mem_rd)
    );
  end

  // ---------------- reference model ----------------
  typedef struct {
    int          inst;
    int          acc;
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [N][65536];
  int          mcount [N];
  int          last_due [N];
  int          cyc;
  int          n_tests;
  int          n_fail;

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cycle %0d: got %h expected %h", nm, g, cyc, act, exp);
    end
  endtask

  task automatic model();
    for (int g = 0; g < N; g++) begin
      int hi;
      hi = -1;
      for (int i = 0; i < sb.size(); i++) begin
        if (sb[i].inst == g) begin
          hi = i;
          break;
        end
      end
      if (reset) begin
        chk("rst_addr_ok", g, 32'(addr_ok[g]), 32'd0);
        chk("rst_data_ok", g, 32'(data_ok[g]), 32'd0);
        chk("rst_rdata",   g, rdata[g], 32'd0);
        chk("rst_ram_en",  g, 32'(ram_en[g]), 32'd0);
        chk("rst_ram_we",  g, 32'(ram_we[g]), 32'd0);
        for (int i = sb.size() - 1; i >= 0; i--)
          if (sb[i].inst == g) sb.delete(i);
        mcount[g]   = 0;
        last_due[g] = cyc;
      end else begin
        int          w;
        logic [31:0] d;
        exp_t        e;
`ifndef SRAM_LIKE_RAND_DELAY_EN
        chk("addr_ok", g, 32'(addr_ok[g]), 32'(mcount[g] < dep_of(g)));
        chk("data_ok", g, 32'(data_ok[g]), 32'((hi >= 0) && (sb[hi].due == cyc)));
`else
        if (addr_ok[g]) chk("addr_ok_room", g, 32'(mcount[g] < dep_of(g)), 32'd1);
`endif
        if (data_ok[g]) begin
          chk("resp_expected", g, 32'(hi >= 0), 32'd1);
          if (hi >= 0) begin
            chk("rdata", g, rdata[g], sb[hi].data);
            chk("lat_min", g, 32'((cyc - sb[hi].acc) >= lat_of(g)), 32'd1);
            sb.delete(hi);
            mcount[g]--;
          end
        end else begin
          chk("rdata_idle", g, rdata[g], 32'd0);
        end
        if (req[g] && addr_ok[g]) begin
          w = int'(addr[g][17:2]);
          chk("ram_en",    g, 32'(ram_en[g]), 32'd1);
          chk("ram_addr",  g, 32'(ram_addr[g]), 32'(w));
          chk("ram_we",    g, 32'(ram_we[g]), wr[g] ? 32'(wstrb[g]) : 32'd0);
          chk("ram_wdata", g, ram_wdata[g], wdata[g]);
          if (wr[g]) begin
            d = ref_mem[g][w];
            for (int b = 0; b < 4; b++)
              if (wstrb[g][b]) d[8*b +: 8] = wdata[g][8*b +: 8];
            ref_mem[g][w] = d;
            e.data = 32'd0;
          end else begin
            e.data = ref_mem[g][w];
          end
          e.inst = g;
          e.acc  = cyc;
          e.due  = (cyc + lat_of(g) > last_due[g] + 1) ? cyc + lat_of(g) : last_due[g] + 1;
          last_due[g] = e.due;
          sb.push_back(e);
          mcount[g]++;
        end else begin
          chk("ram_en_idle", g, 32'(ram_en[g]), 32'd0);
          chk("ram_we_idle", g, 32'(ram_we[g]), 32'd0);
        end
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle_all();
    for (int g = 0; g < N; g++) begin
      req[g] = 1'b0; wr[g] = 1'b0; wstrb[g] = 4'h0;
      addr[g] = 32'd0; wdata[g] = 32'd0; size[g] = 2'd0;
    end
  endtask

  task automatic drive(input int g, input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    req[g] = 1'b1; wr[g] = w; wstrb[g] = s; addr[g] = a; wdata[g] = d; size[g] = 2'd2;
  endtask

  task automatic sample();
    #1;
    model();
  endtask

  task automatic adv();
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    idle_all();
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin
      sample();
      adv();
    end
    chk("drain_empty", 0, 32'(sb.size()), 32'd0);
  endtask

  typedef struct {
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        aok;
    logic        en;
    logic [3:0]  we;
    logic [15:0] raddr;
    logic        dok;
    logic [31:0] rdata;
  } vec_t;

  function automatic vec_t mkv(input logic rq, input logic w, input logic [3:0] s,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic aok, input logic en, input logic [3:0] we,
                               input logic [15:0] ra, input logic dok, input logic [31:0] rd);
    vec_t v;
    v.req = rq; v.wr = w; v.wstrb = s; v.addr = a; v.wdata = d;
    v.aok = aok; v.en = en; v.we = we; v.raddr = ra; v.dok = dok; v.rdata = rd;
    return v;
  endfunction

  vec_t        tbl [11];
  logic [5:0]  sat_aok, sat_dok;
  logic [4:0]  b2b_dok;
  logic [31:0] b2b_rd [5];
  logic [4:0]  rst_dok;
  logic        rst_aok;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    for (int g = 0; g < N; g++) begin
      mcount[g]   = 0;
      last_due[g] = 0;
      for (int w = 0; w < 65536; w++) ref_mem[g][w] = init_word(w);
    end
    idle_all();
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sample();
      adv();
    end
    reset = 1'b0;

`ifndef SRAM_LIKE_RAND_DELAY_EN
    // Instance 0 (DEPTH=2, LATENCY=2): word write, read back, byte write, read back
    tbl[0]  = mkv(1, 1, 4'hF, 32'h40, 32'h12345678, 1, 1, 4'hF, 16'h10, 0, 32'h0);
    tbl[1]  = mkv(0, 0, 4'h0, 32'h0,  32'h0,        1, 0, 4'h0, 16'h0,  0, 32'h0);
    tbl[2]  = mkv(0, 0, 4'h0, 32'h0,  32'h0,        1, 0, 4'h0, 16'h0,  1, 32'h0);
    tbl[3]  = mkv(1, 0, 4'h0, 32'h40, 32'h0,        1, 1, 4'h0, 16'h10, 0, 32'h0);
    tbl[4]  = mkv(0, 0, 4'h0, 32'h0,  32'h0,        1, 0, 4'h0, 16'h0,  0, 32'h0);
    tbl[5]  = mkv(0, 0, 4'h0, 32'h0,  32'h0,        1, 0, 4'h0, 16'h0,  1, 32'h12345678);
    tbl[6]  = mkv(1, 1, 4'h2, 32'h41, 32'h0000AB00, 1, 1, 4'h2, 16'h10, 0, 32'h0);
    tbl[7]  = mkv(1, 0, 4'h0, 32'h40, 32'h0,        1, 1, 4'h0, 16'h10, 0, 32'h0);
    tbl[8]  = mkv(0, 0, 4'h0, 32'h0,  32'h0,        0, 0, 4'h0, 16'h0,  1, 32'h0);
    tbl[9]  = mkv(0, 0, 4'h0, 32'h0,  32'h0,        1, 0, 4'h0, 16'h0,  1, 32'h1234AB78);
    tbl[10] = mkv(0, 0, 4'h0, 32'h0,  32'h0,        1, 0, 4'h0, 16'h0,  0, 32'h0);
    for (int i = 0; i < 11; i++) begin
      idle_all();
      if (tbl[i].req) drive(0, tbl[i].wr, tbl[i].wstrb, tbl[i].addr, tbl[i].wdata);
      sample();
      chk("tbl_addr_ok", 0, 32'(addr_ok[0]), 32'(tbl[i].aok));
      chk("tbl_ram_en",  0, 32'(ram_en[0]),  32'(tbl[i].en));
      chk("tbl_ram_we",  0, 32'(ram_we[0]),  32'(tbl[i].we));
      if (tbl[i].en) chk("tbl_ram_addr", 0, 32'(ram_addr[0]), 32'(tbl[i].raddr));
      chk("tbl_data_ok", 0, 32'(data_ok[0]), 32'(tbl[i].dok));
      chk("tbl_rdata",   0, rdata[0], tbl[i].rdata);
      adv();
    end
    drain();

    // Instance 2 (DEPTH=2, LATENCY=4): req held high, saturation and no same-cycle reopen
    for (int c = 0; c < 6; c++) begin
      idle_all();
      drive(2, 1'b0, 4'h0, 32'(c * 4), 32'd0);
      sample();
      sat_aok[c] = addr_ok[2];
      sat_dok[c] = data_ok[2];
      adv();
    end
    chk("sat_addr_ok", 2, 32'(sat_aok), 32'b100011);
    chk("sat_data_ok", 2, 32'(sat_dok), 32'b110000);
    drain();

    // Instance 1 (DEPTH=4, LATENCY=1): preload 0xA0..0xA3, then back-to-back reads
    for (int c = 0; c < 4; c++) begin
      idle_all();
      drive(1, 1'b1, 4'hF, 32'(c * 4), 32'hA0 + 32'(c));
      sample();
      adv();
    end
    idle_all();
    sample();
    adv();
    for (int c = 0; c < 5; c++) begin
      idle_all();
      if (c < 4) drive(1, 1'b0, 4'h0, 32'(c * 4), 32'd0);
      sample();
      b2b_dok[c] = data_ok[1];
      b2b_rd[c]  = rdata[1];
      adv();
    end
    chk("b2b_data_ok", 1, 32'(b2b_dok), 32'b11110);
    for (int c = 1; c < 5; c++) chk("b2b_rdata", 1, b2b_rd[c], 32'hA0 + 32'(c - 1));
    drain();

    // Instance 2: two reads in flight, then a one-cycle reset before any response
    for (int c = 0; c < 7; c++) begin
      idle_all();
      if (c < 2) drive(2, 1'b0, 4'h0, 32'(16 + c * 4), 32'd0);
      reset = (c == 2);
      sample();
      if (c >= 2) rst_dok[c - 2] = data_ok[2];
      if (c == 3) rst_aok = addr_ok[2];
      adv();
    end
    reset = 1'b0;
    chk("rst_no_resp",   2, 32'(rst_dok), 32'd0);
    chk("rst_reopen_ok", 2, 32'(rst_aok), 32'd1);
    drain();
`endif

    // Random mixed traffic on all instances, with one reset in the middle
    for (int c = 0; c < 1500; c++) begin
      idle_all();
      for (int g = 0; g < N; g++) begin
        if ($urandom_range(0, 99) < 65) begin
          drive(g, 1'($urandom_range(0, 1)), 4'($urandom), 32'($urandom_range(0, 255)), $urandom);
          size[g] = 2'($urandom_range(0, 2));
        end
      end
      reset = (c == 750);
      sample();
      adv();
    end
    reset = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_like_resp.md
Name: sram_like_resp

Overview:
- Responder end of the core's SRAM-like data bus (req / addr_ok / data_ok).
- Accepts requests from the core's EXE/MEM pipeline and issues each one to a single-port synchronous RAM (1-cycle read latency).
- Returns in-order data_ok/rdata responses after a programmable latency, with up to DEPTH requests outstanding.
- Used as the data-side memory model in SoC simulation and as the bridge to on-chip BRAM.

Parameters:
- DEPTH, 2: maximum outstanding (accepted, not yet data_ok'd) requests; power of 2, 1..8.
- LATENCY, 2: minimum cycles from acceptance to data_ok; 1..15.
- ADDR_W, 16: RAM word-address width.
- SEED, 16'hACE1: LFSR seed, optional feature only; must be nonzero.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- data_sram_req  in  1  request valid
- data_sram_wr  in  1  1 = write, 0 = read
- data_sram_size  in  2  0 = byte, 1 = half, 2 = word; informational, byte lanes come from wstrb
- data_sram_wstrb  in  4  write byte enables
- data_sram_addr  in  32  byte address
- data_sram_wdata  in  32  write data
- data_sram_addr_ok  out  1  request accepted this cycle when high together with req
- data_sram_data_ok  out  1  response valid; single-cycle pulse, no back-pressure
- data_sram_rdata  out  32  read data, valid with data_ok
- ram_en  out  1  RAM access enable
- ram_we  out  4  RAM byte write enables
- ram_addr  out  ADDR_W  RAM word address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid the cycle after ram_en

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: addr_ok=0 while reset is high; data_ok=0, rdata=0, ram_en=0, ram_we=0. Outstanding count=0 and the queue is empty.
- addr_ok = ~reset & (count < DEPTH). It depends only on the registered count, with no same-cycle bypass from a retiring response.
- Acceptance: req & addr_ok in cycle T.
  - The RAM is driven combinationally in the same cycle: ram_en=1, ram_addr=addr[ADDR_W+1:2], ram_wdata=wdata, ram_we = wr ? wstrb : 4'b0.
  - The entry is pushed to the queue tail with countdown=LATENCY-1 and is_read=~wr.
- Capture: at T+1, the entry pushed at T latches ram_rdata (read), or 0 (write).
- Countdown: every entry with countdown>0 decrements each cycle.
- Response: data_ok=1 in a cycle when the queue is non-empty, the head countdown is 0 and the head data is captured.
  - rdata = head data; for LATENCY=1 this is a bypass of ram_rdata.
  - At most one data_ok per cycle, strictly in acceptance order. The head pops the same cycle.
  - rdata=0 whenever data_ok=0.
- Timing: first response at exactly T+LATENCY. Back-to-back accepts produce back-to-back data_ok. The queue head may stall later entries beyond their own LATENCY.
- Writes still produce a data_ok with rdata=0.
- Count: +1 on accept, -1 on data_ok; unchanged on simultaneous accept and data_ok.
  - At count==DEPTH, addr_ok stays 0 even in the cycle a response retires. It reasserts the next cycle.
- Pointer wrap-around: the DEPTH-entry circular queue uses pointers with an extra bit for full/empty disambiguation.
- Reset mid-operation: all entries are discarded, with no data_ok for them afterwards. RAM writes already issued are not undone.
- Requests with req low are ignored; the address/data inputs are don't-care then.

Optional Feature:
- Macro: SRAM_LIKE_RAND_DELAY_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) loads SEED on reset and steps every cycle.
  - addr_ok is additionally forced to 0 in any cycle where lfsr[0]=1.
  - Each accepted entry gets an extra delay of lfsr[2:1] cycles (0..3) added to its countdown.
  - Ordering, one-per-cycle and no-loss rules are unchanged.
- Undefined: no LFSR logic; timing is fully deterministic as described above.

Test Plan:
- Single read: preload RAM word 0x10 = 0x12345678; read addr 0x40 at cycle 5 with LATENCY=2 → ram_en=1 with ram_addr=0x10 at cycle 5; data_ok=1 with rdata=0x12345678 at cycle 7 only.
- Byte write then read: write addr 0x41, wstrb=4'b0010, wdata=0x0000AB00 → ram_we=4'b0010 and data_ok with rdata=0 after 2 cycles. A read of 0x40 then returns 0x1234AB78.
- Saturation (DEPTH=2, LATENCY=4): req held high from cycle 0 → accepts at cycles 0 and 1, addr_ok=0 at cycles 2–4. data_ok at cycles 4 and 5; addr_ok=1 again at cycle 5.
- Back-to-back (DEPTH=4, LATENCY=1): 4 reads of words 0..3 holding 0xA0..0xA3 on consecutive cycles → 4 consecutive data_ok pulses in order with rdata 0xA0..0xA3.
- Reset mid-flight: accept 2 reads, assert reset for 1 cycle before any data_ok → no data_ok ever appears for them; count=0; addr_ok=1 the cycle after reset deasserts.
- With SRAM_LIKE_RAND_DELAY_EN and 1000 random reads/writes against a reference memory → every accepted request gets exactly one data_ok, in order, with correct data, and latency ≥ LATENCY.
